// File: rtl/lenet_layer_sequencer.sv
// LeNet layer sequencer: enables each layer engine in turn,
// guards every stage with a watchdog and reports run cycles.
module lenet_layer_sequencer #(
  parameter int N_STAGES = 7,
  parameter int IDX_W    = 3,
  parameter int TIMEOUT  = 1000000,
  parameter int TO_W     = 20,
  parameter int CYC_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_STAGES-1:0] stage_finish,
  output logic [N_STAGES-1:0] stage_en,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IDX_W-1:0]    err_stage,
  output logic [IDX_W-1:0]    cur_stage,
  output logic [CYC_W-1:0]    total_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CYC_W-1:0]    cyc_inc;
  logic [N_STAGES-1:0] en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    errst_q, errst_d;
  logic [CYC_W-1:0]    total_q, total_d;
  logic                fin_cur;
  logic                last;
  logic                wd_to;

  // Next-state, counters and registered output values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    errst_d = errst_q;
    total_d = total_q;
    cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
    fin_cur = |(stage_finish & en_q);
    last    = (idx_q == IDX_W'(N_STAGES - 1));
    wd_to   = (wd_q == TO_W'(TIMEOUT - 1));
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          wd_d    = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
          errst_d = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (fin_cur) begin
          if (last) begin
            state_d = S_DONE;
            total_d = cyc_inc;
          end else begin
            state_d = S_GAP;
          end
        end else if (wd_to) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          errst_d = idx_q;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_GAP: begin
        cyc_d = cyc_inc;
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          state_d = S_RUN;
          idx_d   = idx_q + IDX_W'(1);
          wd_d    = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    en_d = (state_d == S_RUN) ?
           (N_STAGES'(1) << idx_d) : '0;
    busy_d = (state_d == S_RUN) ||
             (state_d == S_GAP) ||
             (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
      cyc_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      errst_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      cyc_q   <= cyc_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      errst_q <= errst_d;
      total_q <= total_d;
    end
  end

  assign stage_en     = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign err_stage    = errst_q;
  assign cur_stage    = idx_q;
  assign total_cycles = total_q;

endmodule
